// File: rtl/std_io_bus_reg_ta_if.sv
// std_io_bus_reg_ta_if: control/status bundle for the registered turnaround pad bus
interface std_io_bus_reg_ta_if #(parameter int WIDTH = 8);
  logic             ena;
  logic             drv_req;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] wr_mask;
  logic             drv_ack;
  logic             busy;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  modport master (output ena, drv_req, wr_data, wr_mask, input drv_ack, busy, rd_data, rd_valid);
  modport slave (input ena, drv_req, wr_data, wr_mask, output drv_ack, busy, rd_data, rd_valid);
endinterface

// File: rtl/std_io_bus_reg_ta.sv
// std_io_bus_reg_ta: registered bidirectional pad bus with per-bit mask, turnaround guard cycles and synchronised capture
module std_io_bus_reg_ta #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  std_io_bus_reg_ta_if.slave    bus_if,
  inout  wire  [WIDTH-1:0]      bus_io
);
  typedef enum logic [1:0] {HIZ, TURN_ON, DRIVE, TURN_OFF} state_t;
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SS = SW'(SYNC_STAGES);
  localparam logic [3:0] TC_M1 = 4'(TURN_CYC == 0 ? 0 : TURN_CYC - 1);
  state_t state, nstate;
  logic [3:0] cnt, ncnt;
  logic [SW-1:0] settle;
  logic load;
  logic [WIDTH-1:0] out_q, oe_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  always_comb begin
    nstate = state;
    ncnt = cnt;
    load = 1'b0;
    case (state)
      HIZ: if (bus_if.drv_req) begin
        nstate = TURN_CYC == 0 ? DRIVE : TURN_ON;
        load = TURN_CYC == 0;
        ncnt = TC_M1;
      end
      TURN_ON: begin
        nstate = !bus_if.drv_req ? HIZ : cnt == 0 ? DRIVE : TURN_ON;
        load = bus_if.drv_req && cnt == 0;
        ncnt = bus_if.drv_req && cnt != 0 ? cnt - 4'd1 : cnt;
      end
      DRIVE: begin
        nstate = bus_if.drv_req ? DRIVE : TURN_CYC == 0 ? HIZ : TURN_OFF;
        load = bus_if.drv_req;
        ncnt = bus_if.drv_req ? cnt : TC_M1;
      end
      default: begin
        nstate = cnt == 0 ? HIZ : TURN_OFF;
        ncnt = cnt == 0 ? cnt : cnt - 4'd1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= HIZ;
      cnt <= '0;
      settle <= '0;
      out_q <= '0;
      oe_q <= '0;
    end else if (bus_if.ena) begin
      state <= nstate;
      cnt <= ncnt;
      settle <= nstate != HIZ ? '0 : (state == HIZ && settle != SS) ? settle + 1'b1 : settle;
      out_q <= load ? bus_if.wr_data : out_q;
      oe_q <= load ? bus_if.wr_mask : '0;
    end
  // capture runs on every clock edge, independent of ena
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus_io;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign bus_io[g] = oe_q[g] ? out_q[g] : 1'bz;
  end
  assign bus_if.drv_ack = state == DRIVE;
  assign bus_if.busy = state == TURN_ON || state == TURN_OFF;
  assign bus_if.rd_valid = state == HIZ && settle == SS;
  assign bus_if.rd_data = sync_q[SYNC_STAGES-1];
endmodule
